lsu_issue_queue: RTL and testbench

In-order issue buffer placed directly upstream of the non-blocking LSU. It accepts load/store micro-ops from dispatch, tracks readiness of their physical source registers via writeback wakeup broadcasts, and presents the oldest operand-ready entry to the LSU, together with PRF read addresses, whenever the LSU reports ready. Memory ops leave strictly in program order; only the head entry is eligible.

---
 rtl/lsu_issue_queue_if.sv | 56 +++++
 rtl/lsu_issue_queue.sv | 125 ++++++++++++
 tb/tb_lsu_issue_queue.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_issue_queue_if.sv
// Dispatch, wakeup, flush and LSU issue signals for the LSU issue queue.
// No latency of its own; master drives dispatch/wakeup/lsu_ready/flush and the slave (queue) answers.
// Backpressure: disp_ready_o toward dispatch, lsu_ready_i from the LSU.
interface lsu_issue_queue_if #(
    parameter int DEPTH              = 4,
    parameter int XLEN               = 64,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int ROB_INDEX_WIDTH    = 4
);
    logic                          flush;
    logic                          disp_valid_i;
    logic                          disp_ready_o;
    logic [ROB_INDEX_WIDTH-1:0]    disp_rob_index_i;
    logic [PHY_REG_ADDR_WIDTH-1:0] disp_rd_addr_i;
    logic [PHY_REG_ADDR_WIDTH-1:0] disp_rs1_addr_i;
    logic [PHY_REG_ADDR_WIDTH-1:0] disp_rs2_addr_i;
    logic                          disp_rs1_ready_i;
    logic                          disp_rs2_ready_i;
    logic [XLEN-1:0]               disp_imm_i;
    logic                          disp_opcode_i;
    logic [1:0]                    disp_size_i;
    logic                          disp_load_sign_i;
    logic                          wake_valid_i;
    logic [PHY_REG_ADDR_WIDTH-1:0] wake_prd_i;
    logic                          lsu_ready_i;
    logic                          issue_valid_o;
    logic [ROB_INDEX_WIDTH-1:0]    issue_rob_index_o;
    logic [PHY_REG_ADDR_WIDTH-1:0] issue_rd_addr_o;
    logic [XLEN-1:0]               issue_imm_o;
    logic                          issue_opcode_o;
    logic [1:0]                    issue_size_o;
    logic                          issue_load_sign_o;
    logic [PHY_REG_ADDR_WIDTH-1:0] issue_rs1_addr_o;
    logic [PHY_REG_ADDR_WIDTH-1:0] issue_rs2_addr_o;
    logic [$clog2(DEPTH):0]        count_o;

    modport master (
        output flush, disp_valid_i, disp_rob_index_i, disp_rd_addr_i, disp_rs1_addr_i,
               disp_rs2_addr_i, disp_rs1_ready_i, disp_rs2_ready_i, disp_imm_i,
               disp_opcode_i, disp_size_i, disp_load_sign_i, wake_valid_i, wake_prd_i,
               lsu_ready_i,
        input  disp_ready_o, issue_valid_o, issue_rob_index_o, issue_rd_addr_o, issue_imm_o,
               issue_opcode_o, issue_size_o, issue_load_sign_o, issue_rs1_addr_o,
               issue_rs2_addr_o, count_o
    );

    modport slave (
        input  flush, disp_valid_i, disp_rob_index_i, disp_rd_addr_i, disp_rs1_addr_i,
               disp_rs2_addr_i, disp_rs1_ready_i, disp_rs2_ready_i, disp_imm_i,
               disp_opcode_i, disp_size_i, disp_load_sign_i, wake_valid_i, wake_prd_i,
               lsu_ready_i,
        output disp_ready_o, issue_valid_o, issue_rob_index_o, issue_rd_addr_o, issue_imm_o,
               issue_opcode_o, issue_size_o, issue_load_sign_o, issue_rs1_addr_o,
               issue_rs2_addr_o, count_o
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order LSU issue buffer: only the head entry issues, once its sources are woken up.
// Latency: dispatch/wakeup to issue is 1 cycle minimum; issue_valid_o is combinational on lsu_ready_i/flush.
// Backpressure: disp_ready_o drops at count==DEPTH (no credit for same-cycle issue); holds head while lsu_ready_i low.
module lsu_issue_queue #(
    parameter int DEPTH              = 4,
    parameter int XLEN               = 64,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int ROB_INDEX_WIDTH    = 4
) (
    input logic               clk,
    input logic               rstn,
    lsu_issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ROB_INDEX_WIDTH-1:0]    rob;
        logic [PHY_REG_ADDR_WIDTH-1:0] rd;
        logic [PHY_REG_ADDR_WIDTH-1:0] rs1;
        logic [PHY_REG_ADDR_WIDTH-1:0] rs2;
        logic [XLEN-1:0]               imm;
        logic                          opcode;
        logic [1:0]                    size;
        logic                          load_sign;
    } entry_t;

    entry_t            r_ent [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_rs1_rdy;
    logic [DEPTH-1:0]  r_rs2_rdy;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    entry_t w_disp_ent;
    entry_t w_head_ent;
    logic   w_not_full;
    logic   w_elig;
    logic   w_enq;
    logic   w_iss;
    logic   w_disp_rs1_rdy;
    logic   w_disp_rs2_rdy;

    always_comb begin
        w_disp_ent           = '0;
        w_disp_ent.rob       = bus.disp_rob_index_i;
        w_disp_ent.rd        = bus.disp_rd_addr_i;
        w_disp_ent.rs1       = bus.disp_rs1_addr_i;
        w_disp_ent.rs2       = bus.disp_rs2_addr_i;
        w_disp_ent.imm       = bus.disp_imm_i;
        w_disp_ent.opcode    = bus.disp_opcode_i;
        w_disp_ent.size      = bus.disp_size_i;
        w_disp_ent.load_sign = bus.disp_load_sign_i;
    end

    // A broadcast in the dispatch cycle would otherwise miss the not-yet-written entry.
    assign w_disp_rs1_rdy = bus.disp_rs1_ready_i ||
                            (bus.wake_valid_i && bus.wake_prd_i == bus.disp_rs1_addr_i);
    assign w_disp_rs2_rdy = bus.disp_rs2_ready_i ||
                            (bus.wake_valid_i && bus.wake_prd_i == bus.disp_rs2_addr_i);

    assign w_not_full = (r_count != FULL_CNT);
    assign w_elig     = r_vld[r_head] && r_rs1_rdy[r_head] &&
                        (!r_ent[r_head].opcode || r_rs2_rdy[r_head]);
    assign w_iss      = w_elig && bus.lsu_ready_i && !bus.flush;
    assign w_enq      = bus.disp_valid_i && w_not_full && !bus.flush;
    assign w_head_ent = r_vld[r_head] ? r_ent[r_head] : '0;

    assign bus.disp_ready_o      = w_not_full;
    assign bus.issue_valid_o     = w_iss;
    assign bus.issue_rob_index_o = w_head_ent.rob;
    assign bus.issue_rd_addr_o   = w_head_ent.rd;
    assign bus.issue_rs1_addr_o  = w_head_ent.rs1;
    assign bus.issue_rs2_addr_o  = w_head_ent.rs2;
    assign bus.issue_imm_o       = w_head_ent.imm;
    assign bus.issue_opcode_o    = w_head_ent.opcode;
    assign bus.issue_size_o      = w_head_ent.size;
    assign bus.issue_load_sign_o = w_head_ent.load_sign;
    assign bus.count_o           = r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_vld     <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else if (bus.flush) begin
            r_vld     <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            if (bus.wake_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_vld[i] && r_ent[i].rs1 == bus.wake_prd_i) r_rs1_rdy[i] <= 1'b1;
                    if (r_vld[i] && r_ent[i].rs2 == bus.wake_prd_i) r_rs2_rdy[i] <= 1'b1;
                end
            end
            // Tail slot is never valid when enqueuing, so this cannot race the wakeup loop.
            if (w_enq) begin
                r_ent[r_tail]     <= w_disp_ent;
                r_vld[r_tail]     <= 1'b1;
                r_rs1_rdy[r_tail] <= w_disp_rs1_rdy;
                r_rs2_rdy[r_tail] <= w_disp_rs2_rdy;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_iss) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_enq, w_iss})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_lsu_issue_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int PW    = 6;
    localparam int RW    = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lsu_issue_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .PHY_REG_ADDR_WIDTH(PW), .ROB_INDEX_WIDTH(RW)) bus ();

    lsu_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .PHY_REG_ADDR_WIDTH(PW), .ROB_INDEX_WIDTH(RW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered list of waiting ops with their source readiness.
    typedef struct {
        logic [RW-1:0]   rob;
        logic [PW-1:0]   rd;
        logic [PW-1:0]   rs1;
        logic [PW-1:0]   rs2;
        logic [XLEN-1:0] imm;
        logic            op;
        logic [1:0]      size;
        logic            sign;
        logic            r1;
        logic            r2;
    } m_t;

    m_t mq[$];

    function automatic logic head_ok();
        if (mq.size() == 0) return 1'b0;
        return mq[0].r1 && (!mq[0].op || mq[0].r2);
    endfunction

    always @(posedge clk or negedge rstn) begin : model_upd
        logic iss;
        logic enq;
        m_t   e;
        if (!rstn || bus.flush) begin
            mq.delete();
        end else begin
            iss = head_ok() && bus.lsu_ready_i;
            enq = bus.disp_valid_i && (mq.size() < DEPTH);
            if (bus.wake_valid_i) begin
                foreach (mq[k]) begin
                    if (mq[k].rs1 == bus.wake_prd_i) mq[k].r1 = 1'b1;
                    if (mq[k].rs2 == bus.wake_prd_i) mq[k].r2 = 1'b1;
                end
            end
            if (iss) void'(mq.pop_front());
            if (enq) begin
                e.rob  = bus.disp_rob_index_i;
                e.rd   = bus.disp_rd_addr_i;
                e.rs1  = bus.disp_rs1_addr_i;
                e.rs2  = bus.disp_rs2_addr_i;
                e.imm  = bus.disp_imm_i;
                e.op   = bus.disp_opcode_i;
                e.size = bus.disp_size_i;
                e.sign = bus.disp_load_sign_i;
                e.r1   = bus.disp_rs1_ready_i || (bus.wake_valid_i && bus.wake_prd_i == bus.disp_rs1_addr_i);
                e.r2   = bus.disp_rs2_ready_i || (bus.wake_valid_i && bus.wake_prd_i == bus.disp_rs2_addr_i);
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic        ev;
        logic [63:0] exp_f;
        logic [63:0] exp_imm;
        ev = head_ok() && bus.lsu_ready_i && !bus.flush;
        exp_f   = '0;
        exp_imm = '0;
        if (mq.size() > 0) begin
            exp_f   = 64'({mq[0].rob, mq[0].rd, mq[0].rs1, mq[0].rs2, mq[0].op, mq[0].size, mq[0].sign});
            exp_imm = mq[0].imm;
        end
        chk("m_issue_valid", 64'(bus.issue_valid_o), 64'(ev));
        chk("m_count", 64'(bus.count_o), 64'(mq.size()));
        chk("m_disp_ready", 64'(bus.disp_ready_o), 64'(mq.size() != DEPTH));
        chk("m_fields", 64'({bus.issue_rob_index_o, bus.issue_rd_addr_o, bus.issue_rs1_addr_o,
                              bus.issue_rs2_addr_o, bus.issue_opcode_o, bus.issue_size_o,
                              bus.issue_load_sign_o}), exp_f);
        chk("m_imm", bus.issue_imm_o, exp_imm);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.disp_valid_i = 1'b0;
        bus.wake_valid_i = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic disp(input logic [RW-1:0] rob, input logic [PW-1:0] rd,
                        input logic [PW-1:0] rs1, input logic r1,
                        input logic [PW-1:0] rs2, input logic r2,
                        input logic [XLEN-1:0] imm, input logic op,
                        input logic [1:0] sz, input logic sg);
        bus.disp_valid_i     = 1'b1;
        bus.disp_rob_index_i = rob;
        bus.disp_rd_addr_i   = rd;
        bus.disp_rs1_addr_i  = rs1;
        bus.disp_rs1_ready_i = r1;
        bus.disp_rs2_addr_i  = rs2;
        bus.disp_rs2_ready_i = r2;
        bus.disp_imm_i       = imm;
        bus.disp_opcode_i    = op;
        bus.disp_size_i      = sz;
        bus.disp_load_sign_i = sg;
    endtask

    initial begin
        idle();
        bus.lsu_ready_i = 1'b0;
        bus.wake_prd_i  = '0;
        disp(4'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 64'd0, 1'b0, 2'd0, 1'b0);
        bus.disp_valid_i = 1'b0;
        step();
        step();
        at_neg();
        chk("rst_issue_valid", 64'(bus.issue_valid_o), 64'd0);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_disp_ready", 64'(bus.disp_ready_o), 64'd1);
        chk("rst_imm", bus.issue_imm_o, 64'd0);
        step();
        rstn = 1'b1;
        step();

        // Basic load
        bus.lsu_ready_i = 1'b1;
        disp(4'd3, 6'd9, 6'd5, 1'b1, 6'd0, 1'b0, 64'h10, 1'b0, 2'd2, 1'b1);
        at_neg();
        chk("basic_no_passthru", 64'(bus.issue_valid_o), 64'd0);
        step();
        idle();
        at_neg();
        chk("basic_iv", 64'(bus.issue_valid_o), 64'd1);
        chk("basic_rob", 64'(bus.issue_rob_index_o), 64'd3);
        chk("basic_rd", 64'(bus.issue_rd_addr_o), 64'd9);
        chk("basic_imm", bus.issue_imm_o, 64'h10);
        chk("basic_cnt1", 64'(bus.count_o), 64'd1);
        step();
        at_neg();
        chk("basic_cnt0", 64'(bus.count_o), 64'd0);

        // Wakeup ordering: store waits on p12, load behind it must not overtake
        step();
        disp(4'd4, 6'd10, 6'd1, 1'b1, 6'd12, 1'b0, 64'h20, 1'b1, 2'd3, 1'b0);
        step();
        disp(4'd5, 6'd11, 6'd2, 1'b1, 6'd0, 1'b0, 64'h30, 1'b0, 2'd3, 1'b0);
        at_neg();
        chk("wk_store_blocked", 64'(bus.issue_valid_o), 64'd0);
        step();
        idle();
        at_neg();
        chk("wk_load_blocked", 64'(bus.issue_valid_o), 64'd0);
        chk("wk_cnt2", 64'(bus.count_o), 64'd2);
        step();
        bus.wake_valid_i = 1'b1;
        bus.wake_prd_i   = 6'd12;
        at_neg();
        chk("wk_no_bypass", 64'(bus.issue_valid_o), 64'd0);
        step();
        idle();
        at_neg();
        chk("wk_store_iv", 64'(bus.issue_valid_o), 64'd1);
        chk("wk_store_rob", 64'(bus.issue_rob_index_o), 64'd4);
        chk("wk_store_op", 64'(bus.issue_opcode_o), 64'd1);
        step();
        at_neg();
        chk("wk_load_iv", 64'(bus.issue_valid_o), 64'd1);
        chk("wk_load_rob", 64'(bus.issue_rob_index_o), 64'd5);
        step();

        // Wakeup in the dispatch cycle
        disp(4'd6, 6'd13, 6'd20, 1'b0, 6'd0, 1'b0, 64'h40, 1'b0, 2'd1, 1'b0);
        bus.wake_valid_i = 1'b1;
        bus.wake_prd_i   = 6'd20;
        step();
        idle();
        at_neg();
        chk("dw_iv", 64'(bus.issue_valid_o), 64'd1);
        chk("dw_rob", 64'(bus.issue_rob_index_o), 64'd6);
        step();

        // Fill to DEPTH while LSU stalls, then drain
        bus.lsu_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(4'(7 + i), 6'(30 + i), 6'd1, 1'b1, 6'd2, 1'b1, 64'(i), 1'b1, 2'(i), 1'b0);
            step();
        end
        idle();
        at_neg();
        chk("full_cnt", 64'(bus.count_o), 64'd4);
        chk("full_drdy", 64'(bus.disp_ready_o), 64'd0);
        step();
        bus.lsu_ready_i = 1'b1;
        disp(4'd11, 6'd40, 6'd1, 1'b1, 6'd2, 1'b1, 64'h99, 1'b0, 2'd0, 1'b1);
        at_neg();
        chk("full_iv", 64'(bus.issue_valid_o), 64'd1);
        chk("full_rob7", 64'(bus.issue_rob_index_o), 64'd7);
        chk("full_no_credit", 64'(bus.disp_ready_o), 64'd0);
        step();
        at_neg();
        chk("full_drdy_back", 64'(bus.disp_ready_o), 64'd1);
        chk("full_rob8", 64'(bus.issue_rob_index_o), 64'd8);
        chk("full_cnt3", 64'(bus.count_o), 64'd3);
        step();
        idle();
        at_neg();
        chk("full_rob9", 64'(bus.issue_rob_index_o), 64'd9);
        chk("full_cnt3b", 64'(bus.count_o), 64'd3);
        step();
        step();
        at_neg();
        chk("full_rob11", 64'(bus.issue_rob_index_o), 64'd11);
        step();
        at_neg();
        chk("full_drained", 64'(bus.count_o), 64'd0);

        // Wrap-around streaming
        step();
        for (int i = 0; i < 10; i++) begin
            disp(4'(i), 6'(i), 6'd3, 1'b1, 6'd4, 1'b1, 64'(100 + i), 1'(i % 2), 2'd3, 1'b0);
            at_neg();
            if (i > 0) begin
                chk("wrap_iv", 64'(bus.issue_valid_o), 64'd1);
                chk("wrap_rob", 64'(bus.issue_rob_index_o), 64'(i - 1));
            end
            chk("wrap_cnt_le1", 64'(bus.count_o <= 1), 64'd1);
            step();
        end
        idle();
        at_neg();
        chk("wrap_last_rob", 64'(bus.issue_rob_index_o), 64'd9);
        step();

        // Flush beats a simultaneous dispatch and an eligible head
        bus.lsu_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            disp(4'(i), 6'(i), 6'd5, 1'b1, 6'd6, 1'b1, 64'(i), 1'b0, 2'd2, 1'b0);
            step();
        end
        disp(4'd4, 6'd4, 6'd5, 1'b1, 6'd6, 1'b1, 64'd4, 1'b0, 2'd2, 1'b0);
        bus.flush       = 1'b1;
        bus.lsu_ready_i = 1'b1;
        at_neg();
        chk("fl_iv", 64'(bus.issue_valid_o), 64'd0);
        chk("fl_cnt_before", 64'(bus.count_o), 64'd3);
        step();
        idle();
        at_neg();
        chk("fl_cnt0", 64'(bus.count_o), 64'd0);
        chk("fl_iv_after", 64'(bus.issue_valid_o), 64'd0);
        chk("fl_drdy", 64'(bus.disp_ready_o), 64'd1);
        step();
        at_neg();
        chk("fl_dropped", 64'(bus.count_o), 64'd0);

        // Asynchronous reset in the middle of operation
        step();
        bus.lsu_ready_i = 1'b0;
        disp(4'd12, 6'd1, 6'd7, 1'b1, 6'd8, 1'b1, 64'h5, 1'b0, 2'd0, 1'b0);
        step();
        disp(4'd13, 6'd2, 6'd7, 1'b1, 6'd8, 1'b1, 64'h6, 1'b0, 2'd0, 1'b0);
        step();
        idle();
        at_neg();
        chk("rr_cnt2", 64'(bus.count_o), 64'd2);
        step();
        bus.lsu_ready_i = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rr_iv", 64'(bus.issue_valid_o), 64'd0);
        chk("rr_cnt", 64'(bus.count_o), 64'd0);
        chk("rr_rob", 64'(bus.issue_rob_index_o), 64'd0);
        step();
        rstn = 1'b1;
        step();
        at_neg();
        chk("rr_empty", 64'(bus.count_o), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
